// File: rtl/camera_init_seq_if.sv
// camera_init_seq_if: write-request bus from the init sequencer to the SCCB
// master, plus the optional readback bus (present only when
// CAMERA_INIT_READBACK_EN is defined).
interface camera_init_seq_if;

    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_reg_addr;
    logic [7:0]  wr_data;

`ifdef CAMERA_INIT_READBACK_EN
    logic        rd_valid;
    logic        rd_ready;
    logic [15:0] rd_reg_addr;
    logic        rd_resp_valid;
    logic [7:0]  rd_resp_data;

    modport master (
        output wr_valid, wr_reg_addr, wr_data,
        input  wr_ready,
        output rd_valid, rd_reg_addr,
        input  rd_ready, rd_resp_valid, rd_resp_data
    );

    modport slave (
        input  wr_valid, wr_reg_addr, wr_data,
        output wr_ready,
        input  rd_valid, rd_reg_addr,
        output rd_ready, rd_resp_valid, rd_resp_data
    );
`else
    modport master (
        output wr_valid, wr_reg_addr, wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_reg_addr, wr_data,
        output wr_ready
    );
`endif

endinterface

// File: rtl/camera_init_seq.sv
// camera_init_seq: walks a register table held in a synchronous ROM and turns
// each entry into an SCCB register write, or into a millisecond wait when the
// entry's register address equals DELAY_MARKER.
// Optional feature: define CAMERA_INIT_READBACK_EN to read every written
// register back (except SKIP_VERIFY_ADDR) and rewrite it on mismatch, giving
// up with error=1 after MAX_RETRY mismatches on one entry.
module camera_init_seq #(
    parameter int          DATA_WIDTH       = 24,
    parameter int          ADDR_WIDTH       = 8,
    parameter int          TABLE_DEPTH      = 252,
    parameter int          CLK_FREQ_HZ      = 50_000_000,
    parameter logic [15:0] DELAY_MARKER     = 16'hFFFF,
    parameter logic [15:0] SKIP_VERIFY_ADDR = 16'h3008,
    parameter int          MAX_RETRY        = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q,
    camera_init_seq_if.master     bus,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] err_idx
);

    // Delay counter is sized for the longest wait (reg_data = 255).
    localparam int CYC_PER_MS    = CLK_FREQ_HZ / 1000;
    localparam int MAX_DELAY_CYC = 255 * CYC_PER_MS;
    localparam int DLY_W         = (MAX_DELAY_CYC > 1) ? $clog2(MAX_DELAY_CYC + 1) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(TABLE_DEPTH - 1);

    // Elaboration-time sanity checks on the configuration.
    if (TABLE_DEPTH < 1 || TABLE_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("camera_init_seq: TABLE_DEPTH must be 1..2**ADDR_WIDTH");
    end
    if (MAX_RETRY < 1) begin : g_bad_retry
        $error("camera_init_seq: MAX_RETRY must be at least 1");
    end
    if (SKIP_VERIFY_ADDR == DELAY_MARKER) begin : g_bad_skip
        $error("camera_init_seq: SKIP_VERIFY_ADDR collides with DELAY_MARKER");
    end

    typedef enum logic [3:0] {
        IDLE, FETCH, WAIT_ROM, DECODE, WRITE, DELAY, READ, CHECK, FIN
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]   rom_addr_q, rom_addr_d;
    logic                    wr_valid_q, wr_valid_d;
    logic [15:0]             wr_reg_addr_q, wr_reg_addr_d;
    logic [7:0]              wr_data_q, wr_data_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [ADDR_WIDTH-1:0]   err_idx_q, err_idx_d;
    logic [DLY_W-1:0]        dly_cnt_q, dly_cnt_d;
    logic                    advance;

`ifdef CAMERA_INIT_READBACK_EN
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    logic                    rd_valid_q, rd_valid_d;
    logic                    error_q, error_d;
    logic [RETRY_W-1:0]      retry_q, retry_d;
`endif

    // Table entry fields as presented by the ROM in DECODE.
    logic [15:0]      rom_reg_addr;
    logic [7:0]       rom_reg_data;
    logic [DLY_W-1:0] rom_delay_cyc;

    assign rom_reg_addr  = rom_q[DATA_WIDTH-1 -: 16];
    assign rom_reg_data  = rom_q[7:0];
    assign rom_delay_cyc = DLY_W'(rom_reg_data) * DLY_W'(CYC_PER_MS);

    // Next-state and registered-output logic of the table walker.
    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d       = state_q;
        idx_d         = idx_q;
        rom_addr_d    = rom_addr_q;
        wr_valid_d    = wr_valid_q;
        wr_reg_addr_d = wr_reg_addr_q;
        wr_data_d     = wr_data_q;
        busy_d        = busy_q;
        done_d        = done_q;
        err_idx_d     = err_idx_q;
        dly_cnt_d     = dly_cnt_q;
        advance       = 1'b0;
`ifdef CAMERA_INIT_READBACK_EN
        rd_valid_d    = rd_valid_q;
        error_d       = error_q;
        retry_d       = retry_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = FETCH;
                    idx_d     = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    err_idx_d = '0;
`ifdef CAMERA_INIT_READBACK_EN
                    error_d   = 1'b0;
                    retry_d   = '0;
`endif
                end
            end

            FETCH: begin
                rom_addr_d = idx_q;
                state_d    = WAIT_ROM;
            end

            WAIT_ROM: state_d = DECODE;

            DECODE: begin
                if (rom_reg_addr == DELAY_MARKER) begin
                    // A zero-length delay costs no wait cycles at all.
                    if (rom_delay_cyc == '0) begin
                        advance = 1'b1;
                    end else begin
                        dly_cnt_d = rom_delay_cyc;
                        state_d   = DELAY;
                    end
                end else begin
                    wr_reg_addr_d = rom_reg_addr;
                    wr_data_d     = rom_reg_data;
                    state_d       = WRITE;
                end
            end

            WRITE: begin
                // First WRITE cycle raises the request; addr/data are already stable.
                if (!wr_valid_q) begin
                    wr_valid_d = 1'b1;
                end else if (bus.wr_ready) begin
                    wr_valid_d = 1'b0;
`ifdef CAMERA_INIT_READBACK_EN
                    if (wr_reg_addr_q != SKIP_VERIFY_ADDR) begin
                        rd_valid_d = 1'b1;
                        state_d    = READ;
                    end else begin
                        advance = 1'b1;
                    end
`else
                    advance = 1'b1;
`endif
                end
            end

            DELAY: begin
                // Loaded with N*K, so DELAY lasts exactly N*K cycles.
                if (dly_cnt_q <= DLY_W'(1)) begin
                    dly_cnt_d = '0;
                    advance   = 1'b1;
                end else begin
                    dly_cnt_d = dly_cnt_q - 1'b1;
                end
            end

`ifdef CAMERA_INIT_READBACK_EN
            READ: begin
                if (bus.rd_ready) begin
                    rd_valid_d = 1'b0;
                    state_d    = CHECK;
                end
            end

            CHECK: begin
                if (bus.rd_resp_valid) begin
                    if (bus.rd_resp_data == wr_data_q) begin
                        advance = 1'b1;
                    end else if (int'(retry_q) + 1 >= MAX_RETRY) begin
                        error_d   = 1'b1;
                        err_idx_d = idx_q;
                        state_d   = FIN;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        state_d = WRITE;
                    end
                end
            end
`endif

            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase

        // Step to the next entry, or finish after the last one (no wrap).
        if (advance) begin
`ifdef CAMERA_INIT_READBACK_EN
            retry_d = '0;
`endif
            if (idx_q == LAST_IDX) begin
                state_d = FIN;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = FETCH;
            end
        end
    end

    // State and output registers; reset abandons any request in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            rom_addr_q    <= '0;
            wr_valid_q    <= 1'b0;
            wr_reg_addr_q <= '0;
            wr_data_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_idx_q     <= '0;
            dly_cnt_q     <= '0;
`ifdef CAMERA_INIT_READBACK_EN
            rd_valid_q    <= 1'b0;
            error_q       <= 1'b0;
            retry_q       <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q       <= state_d;
            idx_q         <= idx_d;
            rom_addr_q    <= rom_addr_d;
            wr_valid_q    <= wr_valid_d;
            wr_reg_addr_q <= wr_reg_addr_d;
            wr_data_q     <= wr_data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_idx_q     <= err_idx_d;
            dly_cnt_q     <= dly_cnt_d;
`ifdef CAMERA_INIT_READBACK_EN
            rd_valid_q    <= rd_valid_d;
            error_q       <= error_d;
            retry_q       <= retry_d;
`endif
        end
    end

    assign rom_addr        = rom_addr_q;
    assign bus.wr_valid    = wr_valid_q;
    assign bus.wr_reg_addr = wr_reg_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err_idx         = err_idx_q;

`ifdef CAMERA_INIT_READBACK_EN
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_reg_addr = wr_reg_addr_q;
    assign error           = error_q;
`else
    assign error           = 1'b0;
`endif

endmodule

// File: tb/tb_camera_init_seq.sv
// tb_camera_init_seq: scoreboard bench for camera_init_seq. Expected writes
// (and, with ready held high, their handshake times) are pushed when a table
// is loaded and popped as the DUT issues write handshakes.
module tb_camera_init_seq;

    localparam int AW    = 8;
    localparam int DW    = 24;
    localparam int DEPTH = 4;
    localparam int FREQ  = 1_000_000;
    localparam int KMS   = FREQ / 1000;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic          start   = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_q;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW-1:0] err_idx;

    camera_init_seq_if bus_if ();

    camera_init_seq #(
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .TABLE_DEPTH     (DEPTH),
        .CLK_FREQ_HZ     (FREQ),
        .DELAY_MARKER    (16'hFFFF),
        .SKIP_VERIFY_ADDR(16'h3008),
        .MAX_RETRY       (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .rom_addr(rom_addr),
        .rom_q   (rom_q),
        .bus     (bus_if),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .err_idx (err_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous ROM model, one cycle of read latency.
    logic [DW-1:0] rom_mem [0:255];
    always @(posedge clk) rom_q <= rom_mem[rom_addr];

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        int          at;   // expected handshake edge relative to start, -1 = untimed
    } wr_exp_t;

    wr_exp_t     exp_q[$];
    int          n_cmp    = 0;
    int          n_err    = 0;
    int          t0       = 0;
    int          hs_count = 0;
    int          rd_count = 0;
    logic [7:0]  regs [logic [15:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Write-handshake monitor: pops the scoreboard on every accepted write.
    initial begin
        forever begin
            @(negedge clk);
            if (bus_if.wr_valid === 1'b1 && bus_if.wr_ready === 1'b1) begin
                wr_exp_t e;
                hs_count++;
                regs[bus_if.wr_reg_addr] = bus_if.wr_data;
                if (exp_q.size() == 0) begin
                    check("wr_unexpected", {16'h0, bus_if.wr_reg_addr}, 32'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", bus_if.wr_reg_addr, e.addr);
                    check("wr_data", bus_if.wr_data, e.data);
                    if (e.at >= 0) check("wr_time", cyc - t0 + 1, e.at);
                end
            end
        end
    end

`ifdef CAMERA_INIT_READBACK_EN
    logic [15:0] corrupt_addr = 16'h0000;
    // Register-file responder: answers each accepted read one cycle later,
    // inverting the data for corrupt_addr to model a stuck register.
    initial begin
        logic        pending = 1'b0;
        logic [15:0] p_addr  = '0;
        bus_if.rd_ready      = 1'b1;
        bus_if.rd_resp_valid = 1'b0;
        bus_if.rd_resp_data  = '0;
        forever begin
            @(negedge clk);
            bus_if.rd_resp_valid = 1'b0;
            if (pending) begin
                bus_if.rd_resp_valid = 1'b1;
                bus_if.rd_resp_data  = regs[p_addr] ^ ((p_addr == corrupt_addr) ? 8'hFF : 8'h00);
                pending = 1'b0;
            end
            if (bus_if.rd_valid && bus_if.rd_ready) begin
                pending = 1'b1;
                p_addr  = bus_if.rd_reg_addr;
                rd_count++;
            end
        end
    end
`endif

    task automatic push_exp(input logic [15:0] addr, input logic [7:0] data, input int at);
        wr_exp_t e;
        e.addr = addr;
        e.data = data;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    // Loads the ROM and predicts writes: a write entry costs 5 cycles, a
    // delay entry 3 + N*KMS; done rises one cycle after the last entry.
    task automatic load_table(input logic [23:0] e0, input logic [23:0] e1,
                              input logic [23:0] e2, input logic [23:0] e3,
                              input bit timed, output int total);
        logic [23:0] tbl [4];
        int cum = 0;
        tbl[0] = e0; tbl[1] = e1; tbl[2] = e2; tbl[3] = e3;
        for (int i = 0; i < 4; i++) begin
            rom_mem[i] = tbl[i];
            if (tbl[i][23:8] == 16'hFFFF) begin
                cum += 3 + int'(tbl[i][7:0]) * KMS;
            end else begin
                cum += 5;
                push_exp(tbl[i][23:8], tbl[i][7:0], timed ? cum : -1);
            end
        end
        total = cum + 1;
    endtask

    task automatic start_seq();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input int budget, output int lat);
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = cyc - t0;
                break;
            end
        end
        if (lat < 0) check("done_timeout", done, 1);
    endtask

    task automatic wait_wr_valid(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus_if.wr_valid) break;
        end
        check("wr_valid_seen", bus_if.wr_valid, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rom_addr"}, rom_addr, 0);
        check({tag, "_wr_valid"}, bus_if.wr_valid, 0);
        check({tag, "_wr_addr"},  bus_if.wr_reg_addr, 0);
        check({tag, "_wr_data"},  bus_if.wr_data, 0);
        check({tag, "_busy"},     busy, 0);
        check({tag, "_done"},     done, 0);
        check({tag, "_error"},    error, 0);
        check({tag, "_err_idx"},  err_idx, 0);
`ifdef CAMERA_INIT_READBACK_EN
        check({tag, "_rd_valid"}, bus_if.rd_valid, 0);
`endif
    endtask

    // Checks a completed, ready-held run: latency, write count, empty scoreboard.
    task automatic finish_run(input string tag, input int total, input int hs0, input int n_wr);
        int lat;
        wait_done(total + 50, lat);
        check({tag, "_latency"}, lat, total);
        check({tag, "_writes"},  hs_count - hs0, n_wr);
        check({tag, "_sb_left"}, exp_q.size(), 0);
        check({tag, "_busy"},    busy, 0);
        check({tag, "_error"},   error, 0);
    endtask

    initial begin
        int total;
        int hs0;
        int lat;
        bus_if.wr_ready = 1'b1;
        for (int i = 0; i < 256; i++) rom_mem[i] = '0;

        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);

`ifndef CAMERA_INIT_READBACK_EN
        // Four plain writes, ready held high: 5 cycles each, done 21 after start.
        load_table({16'h3012, 8'h80}, {16'h3103, 8'h11}, {16'h4300, 8'h30}, {16'h5001, 8'hA7}, 1'b1, total);
        hs0 = hs_count;
        start_seq();
        finish_run("plain", total, hs0, 4);
        check("plain_done_cycle", total, 21);
        repeat (5) @(posedge clk);
        #1 check("plain_done_hold", done, 1);

        // Ready stalled 10 cycles on entry 0: request must stay stable.
        #1 bus_if.wr_ready = 1'b0;
        load_table({16'h3820, 8'h46}, {16'h3821, 8'h01}, {16'h3814, 8'h31}, {16'h3815, 8'h31}, 1'b0, total);
        hs0 = hs_count;
        start_seq();
        wait_wr_valid(20);
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", bus_if.wr_valid, 1);
            check("stall_addr",  bus_if.wr_reg_addr, 16'h3820);
            check("stall_data",  bus_if.wr_data, 8'h46);
            @(negedge clk);
        end
        @(posedge clk); #1 bus_if.wr_ready = 1'b1;
        wait_done(200, lat);
        check("stall_writes",  hs_count - hs0, 4);
        check("stall_sb_left", exp_q.size(), 0);

        // 5 ms delay entry: 5000 idle cycles, no write for it.
        load_table({16'h3008, 8'h82}, {16'hFFFF, 8'h05}, {16'h3103, 8'h03}, {16'h3017, 8'hFF}, 1'b1, total);
        hs0 = hs_count;
        start_seq();
        finish_run("dly5", total, hs0, 3);

        // Zero-length delay entry: no wait.
        load_table({16'h3008, 8'h02}, {16'hFFFF, 8'h00}, {16'h3034, 8'h1A}, {16'h3035, 8'h21}, 1'b1, total);
        hs0 = hs_count;
        start_seq();
        finish_run("dly0", total, hs0, 3);

        // Reset mid-WRITE, then a fresh start restarts from entry 0.
        #1 bus_if.wr_ready = 1'b0;
        load_table({16'h3036, 8'h69}, {16'h3037, 8'h13}, {16'h3108, 8'h01}, {16'h3630, 8'h36}, 1'b0, total);
        start_seq();
        wait_wr_valid(20);
        @(posedge clk); #1 reset_n = 1'b0;
        #1 check_reset_outputs("rst_async");
        exp_q.delete();
        @(posedge clk); #1 check_reset_outputs("rst_edge");
        @(posedge clk); #1 reset_n = 1'b1;
        bus_if.wr_ready = 1'b1;
        hs0 = hs_count;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_rst_idle_valid", bus_if.wr_valid, 0);
            check("post_rst_idle_busy",  busy, 0);
        end
        load_table({16'h3036, 8'h69}, {16'h3037, 8'h13}, {16'h3108, 8'h01}, {16'h3630, 8'h36}, 1'b1, total);
        start_seq();
        finish_run("restart", total, hs0, 4);

        // Start pulsed while busy is ignored.
        load_table({16'h3631, 8'h0E}, {16'h3632, 8'hE2}, {16'h3633, 8'h12}, {16'h3621, 8'hE0}, 1'b1, total);
        hs0 = hs_count;
        start_seq();
        repeat (6) @(posedge clk);
        #1 start = 1'b1;
        check("busy_at_restart", busy, 1);
        @(posedge clk); #1 start = 1'b0;
        finish_run("ign_start", total, hs0, 4);
        repeat (10) @(posedge clk);
        #1 check("ign_start_no_rerun", busy, 0);
`else
        // Clean readback: entry 1 is the skip address, so only 3 reads.
        load_table({16'h0100, 8'h11}, {16'h3008, 8'h22}, {16'h0300, 8'h33}, {16'h0400, 8'h44}, 1'b0, total);
        hs0 = hs_count;
        rd_count = 0;
        start_seq();
        wait_done(500, lat);
        check("rb_ok_writes",  hs_count - hs0, 4);
        check("rb_ok_reads",   rd_count, 3);
        check("rb_ok_error",   error, 0);
        check("rb_ok_sb_left", exp_q.size(), 0);

        // Entry 2 always reads back wrong: three writes, then error.
        corrupt_addr = 16'h0300;
        load_table({16'h0100, 8'h11}, {16'h3008, 8'h22}, {16'h0300, 8'h33}, {16'h0400, 8'h44}, 1'b0, total);
        void'(exp_q.pop_back());
        push_exp(16'h0300, 8'h33, -1);
        push_exp(16'h0300, 8'h33, -1);
        hs0 = hs_count;
        rd_count = 0;
        start_seq();
        wait_done(500, lat);
        check("rb_err_writes",  hs_count - hs0, 5);
        check("rb_err_reads",   rd_count, 4);
        check("rb_err_error",   error, 1);
        check("rb_err_idx",     err_idx, 2);
        check("rb_err_done",    done, 1);
        check("rb_err_busy",    busy, 0);
        check("rb_err_sb_left", exp_q.size(), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
        $fatal(1);
    end

endmodule

// File: doc/camera_init_seq.md
CAMERA_INIT_SEQ -- requirements
Module: camera_init_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, giving the table entry width as {reg_addr[15:0], reg_data[7:0]}.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, giving the table address width.
REQ-003 SHALL have parameter TABLE_DEPTH, default 252, giving the number of entries walked, legal range 1..2^ADDR_WIDTH.
REQ-004 SHALL have parameter CLK_FREQ_HZ, default 50_000_000, giving the clk frequency used for ms delays.
REQ-005 SHALL have parameter DELAY_MARKER, default 16'hFFFF, giving the reg_addr value that denotes a delay entry.
REQ-006 SHALL have parameter SKIP_VERIFY_ADDR, default 16'h3008, giving a register that is never read back.
REQ-007 SHALL have parameter MAX_RETRY, default 3, giving the maximum rewrite attempts per entry on readback mismatch.
REQ-008 SHALL have ports clk (in, 1, clock) and reset_n (in, 1, asynchronous active-low reset).
REQ-009 SHALL have ports start (in, 1, pulse that begins a sequence), rom_addr (out, ADDR_WIDTH, table address), and rom_q (in, DATA_WIDTH, entry data registered with 1-cycle latency).
REQ-010 SHALL have ports wr_valid (out, 1), wr_ready (in, 1), wr_reg_addr (out, 16), and wr_data (out, 8), forming the write request to the SCCB master.
REQ-011 SHALL have ports busy (out, 1), done (out, 1), error (out, 1), and err_idx (out, ADDR_WIDTH, index of the failing entry).
REQ-012 SHALL have ports rd_valid (out, 1), rd_ready (in, 1), rd_reg_addr (out, 16), rd_resp_valid (in, 1), and rd_resp_data (in, 8), present only with the macro defined.

Function
REQ-013 SHALL implement states IDLE, FETCH, WAIT_ROM, DECODE, WRITE, DELAY, READ, CHECK, and FIN.
REQ-014 SHALL move from IDLE to FETCH on start=1, setting idx to 0, busy to 1, and clearing done, error, and err_idx.
REQ-015 SHALL ignore start while busy=1.
REQ-016 SHALL in FETCH drive rom_addr=idx, then spend one WAIT_ROM cycle, then latch rom_q in DECODE.
REQ-017 SHALL in DECODE go to DELAY when reg_addr==DELAY_MARKER and to WRITE otherwise.
REQ-018 SHALL in WRITE assert wr_valid with wr_reg_addr and wr_data held stable until the cycle in which wr_valid and wr_ready are both 1, then deassert wr_valid in the next cycle.
REQ-019 SHALL in DELAY wait reg_data*(CLK_FREQ_HZ/1000) cycles, computing the counter width from the parameters with no overflow at reg_data=255.
REQ-020 SHALL treat a delay entry with reg_data=0 as taking zero wait cycles.
REQ-021 SHALL advance an entry by incrementing idx and going to FETCH, or to FIN when idx==TABLE_DEPTH-1, with no wrap to 0.
REQ-022 SHALL in FIN assert done=1 and busy=0 and return to IDLE, with done holding until the next accepted start.
REQ-023 SHALL, when wr_ready is held 1, take exactly 5 cycles per write entry, from FETCH to the next FETCH.
REQ-024 SHALL make rom_addr hold its last value outside FETCH.

Reset
REQ-025 SHALL on reset_n=0 asynchronously force state=IDLE, idx=0, rom_addr=0, wr_valid=0, rd_valid=0, wr_reg_addr=0, wr_data=0, busy=0, done=0, error=0, err_idx=0, and clear the delay and retry counters.
REQ-026 SHALL abandon any request in flight when reset is asserted mid-sequence, with no replay after reset release until a new start.

Configuration
REQ-027 SHALL recognise the macro CAMERA_INIT_READBACK_EN.
REQ-028 SHALL, with CAMERA_INIT_READBACK_EN defined, follow each accepted write whose reg_addr!=SKIP_VERIFY_ADDR with READ, asserting rd_valid and rd_reg_addr until rd_ready.
REQ-029 SHALL, with CAMERA_INIT_READBACK_EN defined, go to CHECK and wait for rd_resp_valid.
REQ-030 SHALL, with CAMERA_INIT_READBACK_EN defined, advance to the next entry on a match.
REQ-031 SHALL, with CAMERA_INIT_READBACK_EN defined, on a mismatch return to WRITE and increment retry.
REQ-032 SHALL, with CAMERA_INIT_READBACK_EN defined, once MAX_RETRY mismatches have occurred, set error=1 and err_idx=idx and go to FIN.
REQ-033 SHALL, with CAMERA_INIT_READBACK_EN defined, clear retry at each new entry.
REQ-034 SHALL, with CAMERA_INIT_READBACK_EN undefined, have no read ports, READ and CHECK unreachable, and error held constant at 0.

Verification
REQ-035 SHALL cover: TABLE_DEPTH=4, wr_ready=1, no delay entries -> 4 write handshakes with exact addr/data, done at cycle 21 after start.
REQ-036 SHALL cover: wr_ready held low for 10 cycles on entry 0 -> wr_valid/addr/data stable for 10 cycles, single handshake.
REQ-037 SHALL cover: entry {FFFF,05} with CLK_FREQ_HZ=1000000 -> 5000 idle cycles, no write issued; entry {FFFF,00} -> no wait.
REQ-038 SHALL cover: reset_n low mid-WRITE -> all outputs reset next edge; start after release -> restarts from idx 0.
REQ-039 SHALL cover: with macro, model returns wrong data 3 times at idx 2 -> 3 writes of entry 2, error=1, err_idx=2, done=1.
REQ-040 SHALL cover: start pulsed while busy -> ignored, sequence order unchanged.
